// File: rtl/random_arbiter.sv
// Round-robin arbiter handing out draws from a shared 16-bit LFSR; grant and draw are registered,
// one cycle after req is seen in IDLE, and the LFSR is stirred between draws (busy while not IDLE).
module random_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          DRAW_STEPS = 16,
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [15:0]        rnd_out,
    output logic               rnd_valid,
    output logic               busy,
    input  logic               seed_load,
    input  logic [15:0]        seed_in
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (DRAW_STEPS > 1) ? $clog2(DRAW_STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STIR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [15:0]        rnd_out_q, rnd_out_d;
    logic               rnd_valid_q, rnd_valid_d;

    logic [15:0]        lfsr_step;
    logic [15:0]        seed_fix;
    logic               win_vld;
    logic [LW-1:0]      win_idx;

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seed_fix  = (seed_in == 16'h0000) ? 16'h0001 : seed_in;

    // First requester after the previous winner, wrapping modulo NUM_REQ.
    always_comb begin
        logic [LW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = LW'((int'(last_q) + k) % NUM_REQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = '0;
        rnd_out_d   = rnd_out_q;
        rnd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = seed_fix;
                end else if (win_vld) begin
                    state_d     = GRANT;
                    gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    rnd_out_d   = lfsr_q;
                    rnd_valid_d = 1'b1;
                    last_d      = win_idx;
                end
            end
            GRANT: begin
                if (seed_load) begin
                    lfsr_d  = seed_fix;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = STIR;
                    cnt_d   = CW'(DRAW_STEPS - 1);
                    lfsr_d  = lfsr_step;
                end
            end
            STIR: begin
                // The exit edge does not shift, so the GRANT->STIR shift plus the
                // counted shifts add up to exactly DRAW_STEPS per draw.
                if (seed_load) begin
                    lfsr_d  = seed_fix;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= RESET_SEED;
            cnt_q       <= '0;
            last_q      <= LW'(NUM_REQ - 1);
            gnt_q       <= '0;
            rnd_out_q   <= 16'h0000;
            rnd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rnd_out_q   <= rnd_out_d;
            rnd_valid_q <= rnd_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_out_q;
    assign rnd_valid = rnd_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_random_arbiter.sv
// Bench for random_arbiter: directed scenarios, then randomized traffic against a transaction-level model.
module tb_random_arbiter;

    localparam int          NREQ = 4;
    localparam int          D    = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rnd_out;
    logic            rnd_valid;
    logic            busy;
    logic            seed_load = 1'b0;
    logic [15:0]     seed_in = '0;

    random_arbiter #(.NUM_REQ(NREQ), .DRAW_STEPS(D), .RESET_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .rnd_out(rnd_out),
        .rnd_valid(rnd_valid), .busy(busy), .seed_load(seed_load), .seed_in(seed_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: LFSR value that the next draw will deliver, busy cycles left, last winner.
    logic [15:0]     m_lfsr = SEED;
    int              m_busy = 0;
    int              m_last = NREQ - 1;
    logic [NREQ-1:0] e_gnt = '0;
    logic            e_vld = 1'b0;
    logic [15:0]     e_rnd = '0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++)
            x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        return x;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (((r >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic sl, input logic [15:0] sd, input logic rs);
        int w;
        if (rs) begin
            m_lfsr = SEED; m_busy = 0; m_last = NREQ - 1;
            e_gnt = '0; e_vld = 1'b0; e_rnd = '0;
        end else begin
            e_gnt = '0;
            e_vld = 1'b0;
            if (sl) begin
                m_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
                m_busy = 0;
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (r != '0) begin
                w      = rr_pick(r, m_last);
                e_gnt  = NREQ'(1) << w;
                e_vld  = 1'b1;
                e_rnd  = m_lfsr;
                m_lfsr = lfsr_adv(m_lfsr, D);
                m_busy = D + 1;
                m_last = w;
            end
        end
    endtask

    task automatic tick(input logic [NREQ-1:0] r, input logic sl, input logic [15:0] sd, input logic rs);
        req = r; seed_load = sl; seed_in = sd; reset = rs;
        @(posedge clk);
        model_edge(r, sl, sd, rs);
        #1;
        cyc++;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rnd_valid", 32'(rnd_valid), 32'(e_vld));
        chk("rnd_out", 32'(rnd_out), 32'(e_rnd));
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, 16'h0, 1'b0);
    endtask

    logic [NREQ-1:0] rr_exp [5];
    logic [NREQ-1:0] drop;
    int              ng;
    int              last_cyc;

    initial begin
        // 1: reset and first draw
        tick('0, 1'b0, 16'h0, 1'b1);
        tick('0, 1'b0, 16'h0, 1'b1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rnd", 32'(rnd_out), 32'd0);
        tick(4'b0001, 1'b0, 16'h0, 1'b0);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_rnd", 32'(rnd_out), 32'hACE1);
        drain(D + 1);

        // 2: seeded sequence
        tick('0, 1'b1, 16'h0001, 1'b0);
        tick(4'b0001, 1'b0, 16'h0, 1'b0);
        chk("t2_draw1", 32'(rnd_out), 32'h0001);
        drain(D + 1);
        tick(4'b0010, 1'b0, 16'h0, 1'b0);
        chk("t2_draw2", 32'(rnd_out), 32'h002D);
        drain(D + 1);

        // 3: round-robin with all requesters active
        tick('0, 1'b0, 16'h0, 1'b1);
        tick('0, 1'b0, 16'h0, 1'b1);
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        drop = '0; ng = 0; last_cyc = 0;
        for (int c = 0; c < 120 && ng < 5; c++) begin
            tick(4'b1111 & ~drop, 1'b0, 16'h0, 1'b0);
            drop = gnt;
            if (gnt != '0) begin
                chk("rr_order", 32'(gnt), 32'(rr_exp[ng]));
                if (ng > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd18);
                last_cyc = cyc;
                ng++;
            end
        end
        chk("rr_count", 32'(ng), 32'd5);
        drain(D + 1);

        // 4: zero seed becomes 1
        tick('0, 1'b1, 16'h0000, 1'b0);
        tick(4'b0001, 1'b0, 16'h0, 1'b0);
        chk("t4_rnd", 32'(rnd_out), 32'h0001);

        // 5: seed_load collisions (currently in GRANT)
        tick('0, 1'b1, 16'h1234, 1'b0);
        chk("t5_grant_busy", 32'(busy), 32'd0);
        chk("t5_grant_gnt", 32'(gnt), 32'd0);
        tick(4'b0010, 1'b0, 16'h0, 1'b0);
        chk("t5_after_grant_rnd", 32'(rnd_out), 32'h1234);
        tick('0, 1'b0, 16'h0, 1'b0);
        chk("t5_stir_busy", 32'(busy), 32'd1);
        tick('0, 1'b1, 16'h5555, 1'b0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        tick(4'b0100, 1'b1, 16'h7777, 1'b0);
        chk("t5_idle_nogrant", 32'(gnt), 32'd0);
        tick(4'b0100, 1'b0, 16'h0, 1'b0);
        chk("t5_delayed_gnt", 32'(gnt), 32'h4);
        chk("t5_delayed_rnd", 32'(rnd_out), 32'h7777);
        drain(3);

        // 6: reset mid-STIR
        tick('0, 1'b0, 16'h0, 1'b1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_gnt", 32'(gnt), 32'd0);
        tick(4'b0001, 1'b0, 16'h0, 1'b0);
        chk("t6_rnd", 32'(rnd_out), 32'hACE1);
        drain(D + 1);

        // 7: randomized traffic
        drop = '0;
        for (int c = 0; c < 1500; c++) begin
            logic [NREQ-1:0] r;
            logic            sl, rs;
            logic [15:0]     sd;
            r  = NREQ'($urandom) & ~drop;
            sl = ($urandom_range(0, 39) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rs = ($urandom_range(0, 199) == 0);
            tick(r, sl, sd, rs);
            drop = gnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
